// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised raster timing generator. Produces horizontal and
//            vertical sync with configurable porches, widths and polarity,
//            a blank_n strobe, scaled pixel coordinates for tiled/low-res
//            framebuffers, and line/frame start pulses. Advances only on a
//            pixel-enable tick and can be parked at the frame origin.
// Ports    : clk0        - system clock
//            rst         - asynchronous active-high reset
//            pix_en      - pixel tick; state advances only when high
//            run         - 1 = generate timing, 0 = hold at frame origin
//            h_sync      - horizontal sync, active level H_POL
//            v_sync      - vertical sync, active level V_POL
//            blank_n     - high inside the visible region
//            pos_x/pos_y - scaled column/row inside the active region, else 0
//            line_start  - one-cycle pulse on the tick h_cnt becomes 0
//            frame_start - one-cycle pulse on the tick h_cnt and v_cnt become 0
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int X_SCALE  = 5,
    parameter int Y_SCALE  = 15,
    parameter int CW       = 11
) (
    input  logic          clk0,
    input  logic          rst,
    input  logic          pix_en,
    input  logic          run,
    output logic          h_sync,
    output logic          v_sync,
    output logic          blank_n,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_LAST = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_LAST = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [CW-1:0] X_LAST  = CW'(X_SCALE - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(Y_SCALE - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic          H_ON    = (H_POL != 0);
    localparam logic          V_ON    = (V_POL != 0);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [CW-1:0] x_sub_q, x_sub_d;
    logic [CW-1:0] y_sub_q, y_sub_d;
    logic [CW-1:0] pos_x_q, pos_x_d;
    logic [CW-1:0] pos_y_q, pos_y_d;
    logic          running_q, running_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          blank_n_q, blank_n_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          h_wrap;

    // All registered outputs are derived from the next-state counters so
    // they describe the counter values held in the same cycle.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        x_sub_d       = x_sub_q;
        y_sub_d       = y_sub_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        running_d     = running_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        blank_n_d     = blank_n_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        h_wrap        = 1'b0;

        if (!run) begin
            // Parked at the origin with idle outputs, regardless of pix_en.
            running_d = 1'b0;
            h_cnt_d   = '0;
            v_cnt_d   = '0;
            x_sub_d   = '0;
            y_sub_d   = '0;
            pos_x_d   = '0;
            pos_y_d   = '0;
            h_sync_d  = ~H_ON;
            v_sync_d  = ~V_ON;
            blank_n_d = 1'b0;
        end else if (pix_en) begin
            running_d = 1'b1;
            if (!running_q) begin
                // First tick after reset or a run stop: present the origin
                // itself rather than advancing past it.
                h_cnt_d = '0;
                v_cnt_d = '0;
                x_sub_d = '0;
                y_sub_d = '0;
                pos_x_d = '0;
                pos_y_d = '0;
            end else begin
                h_wrap  = (h_cnt_q == H_LAST);
                h_cnt_d = h_wrap ? '0 : h_cnt_q + ONE;
                if (h_wrap) begin
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + ONE;
                end

                // Column scaler: sub-counter carries into pos_x, cleared
                // at line start and outside the active columns.
                if (h_cnt_d == '0 || h_cnt_d >= H_VIS) begin
                    x_sub_d = '0;
                    pos_x_d = '0;
                end else if (x_sub_q == X_LAST) begin
                    x_sub_d = '0;
                    pos_x_d = pos_x_q + ONE;
                end else begin
                    x_sub_d = x_sub_q + ONE;
                end

                // Row scaler steps once per line.
                if (h_wrap) begin
                    if (v_cnt_d == '0 || v_cnt_d >= V_VIS) begin
                        y_sub_d = '0;
                        pos_y_d = '0;
                    end else if (y_sub_q == Y_LAST) begin
                        y_sub_d = '0;
                        pos_y_d = pos_y_q + ONE;
                    end else begin
                        y_sub_d = y_sub_q + ONE;
                    end
                end
            end

            h_sync_d      = (h_cnt_d >= HS_BEG && h_cnt_d <= HS_LAST) ? H_ON : ~H_ON;
            v_sync_d      = (v_cnt_d >= VS_BEG && v_cnt_d <= VS_LAST) ? V_ON : ~V_ON;
            blank_n_d     = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
            line_start_d  = (h_cnt_d == '0);
            frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
        end
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_sub_q       <= '0;
            y_sub_q       <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            running_q     <= 1'b0;
            h_sync_q      <= ~H_ON;
            v_sync_q      <= ~V_ON;
            blank_n_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_sub_q       <= x_sub_d;
            y_sub_q       <= y_sub_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            running_q     <= running_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            blank_n_q     <= blank_n_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign blank_n     = blank_n_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA sync generator. Produces h_sync/v_sync with configurable porch/sync widths and polarities, a blank_n strobe, scaled pixel coordinates for tile/low-res framebuffers, and line/frame start pulses for the display fetch pipeline. Runs on the system clock, advancing only on a pixel-enable tick, and can be held idle by a run control.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BACK, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_POL, 0, h_sync active level (0 = active low)
V_POL, 0, v_sync active level (0 = active low)
X_SCALE, 5, screen pixels per pos_x step (>=1)
Y_SCALE, 15, screen lines per pos_y step (>=1)
CW, 11, width of counters and pos outputs

Ports:
clk0  in  1  system clock
rst  in  1  asynchronous, active-high reset
pix_en  in  1  pixel tick; all state advances only when high
run  in  1  1 = generate timing; 0 = hold at frame origin
h_sync  out  1  horizontal sync, level per H_POL
v_sync  out  1  vertical sync, level per V_POL
blank_n  out  1  1 inside visible region
pos_x  out  CW  scaled column, h_cnt / X_SCALE in active, else 0
pos_y  out  CW  scaled row, v_cnt / Y_SCALE in active, else 0
line_start  out  1  one-cycle pulse on tick where h_cnt becomes 0
frame_start  out  1  one-cycle pulse on tick where h_cnt and v_cnt become 0

Behaviour:
- Line order: active [0, H_ACTIVE-1], front porch, sync, back porch; H_TOTAL = sum of all four. Vertical order is the same in lines; V_TOTAL likewise.
- Internal h_cnt, v_cnt, x_sub (0..X_SCALE-1), y_sub (0..Y_SCALE-1). No dividers or multipliers: scaled coordinates use sub-counters only.
- Reset (async): h_cnt = v_cnt = 0, subs 0, pos 0, h_sync = v_sync = inactive (~POL), blank_n = 0, pulses 0.
- All outputs are registered and describe the counter state held in the same cycle: each is computed from next-state on the updating edge. Zero added latency relative to counters.
- Cycle with pix_en = 0: all state holds; line_start and frame_start read 0.
- Tick with run = 1: h_cnt wraps at H_TOTAL-1 to 0, else increments. On wrap, v_cnt wraps at V_TOTAL-1, else increments.
- h_sync is active when h_cnt is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
- v_sync is active when v_cnt is in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1]. It changes only with v_cnt, i.e. at h_cnt = 0.
- blank_n = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- pos_x: x_sub increments per active tick and wraps at X_SCALE-1; pos_x increments on that wrap. Both go to 0 when h_cnt leaves the active region.
- pos_y: y_sub/pos_y advance on h_cnt wrap while v_cnt is active. Both go to 0 when v_cnt leaves active.
- Non-divisible active widths are allowed; the last pos value is partial.
- line_start = 1 for one tick when the new h_cnt is 0. frame_start additionally requires the new v_cnt to be 0.
- run = 0 (sampled on any clock): next state is the origin (h_cnt = v_cnt = 0, subs 0). Syncs are inactive, blank_n = 0, pos = 0, pulses 0.
- Restarting from run = 0: the first tick with run = 1 leaves counters at the origin, then advances normally. frame_start and line_start fire on that first tick.
- Reset asserted mid-line: outputs go to reset values immediately (asynchronously). After release, the first pix_en tick behaves as a restart from the origin.
- Simultaneous events: run = 0 dominates pix_en; rst dominates all.

Test Plan:
- Defaults, pix_en = 1, run = 1, 2 frames -> h_sync low for exactly 96 ticks starting at h_cnt 656. Line period is 800 ticks. v_sync is low on lines 490-491. Frame period is 420000 ticks. One frame_start per frame.
- Defaults, active line 0 -> blank_n high for ticks 0-639. pos_x steps every 5 ticks, reaching 127 at tick 639, then 0. pos_y = 31 on lines 465-479, 0 on line 480.
- pix_en toggling 1-of-2 -> every period doubles (line = 1600 clocks). Outputs are stable on non-tick cycles, and pulses never last more than one clock.
- rst asserted at h_cnt 300, v_cnt 100 -> all outputs reach reset values without a clock edge. After release plus the first tick, frame_start = 1 and blank_n = 1.
- run dropped mid-frame, then raised -> outputs idle (blank_n = 0, syncs inactive) while low. The first tick after run rises gives frame_start = 1, pos_x = 0, pos_y = 0.
- H_POL = 1, V_POL = 1, X_SCALE = 1, Y_SCALE = 1, H_ACTIVE = 8, H_FRONT = 2, H_SYNC = 2, H_BACK = 2, V_ACTIVE = 4, V_FRONT = V_SYNC = V_BACK = 1 -> h_sync high on ticks 10-11 of the 14-tick line. v_sync high on line 5 of 7. pos_x equals h_cnt over 0-7.
